// File: rtl/au_neg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// au_neg_pipe_pkg
// Shared definitions for the pipelined negate/abs unit:
//   - neg_mode_e    : per-lane operation encoding
//   - neg_stage_t   : side-band bits that travel with a lane's data through
//                     each stage register (neg enable, ovf candidate, carry)
//   - chunkSize()   : bits of carry chain resolved per pipeline stage
// No ports (package).
// ---------------------------------------------------------------------------
package au_neg_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_NEG  = 2'd1,
        MODE_ABS  = 2'd2,
        MODE_NEG2 = 2'd3
    } neg_mode_e;

    // The stage valid bit is shared by all lanes and lives in the top;
    // each lane keeps its data word in a separate register array next to this.
    typedef struct packed {
        logic negEn;
        logic ovfCand;
        logic carry;
    } neg_stage_t;

    // ceil(width / stages); the last chunk may be shorter or even empty.
    function automatic int chunkSize(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/au_neg_pipe_lane.sv
// ---------------------------------------------------------------------------
// au_neg_pipe_lane
// One lane of the negate/abs unit. The two's-complement carry chain is cut
// into STAGES chunks; stage k inverts chunk k (when negating) and adds the
// carry handed over from stage k-1. Upper chunks ride along unprocessed.
// Optional feature: define AU_NEG_PIPE_SAT_EN to saturate an overflowing
// negation to the most-positive value in the last stage.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   advance_i    : global pipeline advance from the top (load vs hold)
//   mode_i       : lane operation (neg_mode_e encoding)
//   data_i       : lane operand
//   data_o       : registered lane result
//   ovf_o        : registered overflow flag (negation of 100...0)
// ---------------------------------------------------------------------------
module au_neg_pipe_lane
    import au_neg_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ovf_o
);

    localparam int CHUNK = chunkSize(WIDTH, STAGES);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    neg_mode_e        mode;
    logic             inNegEn;
    neg_stage_t       inFlags;

    logic [WIDTH-1:0] data_q  [STAGES];
    logic [WIDTH-1:0] data_d  [STAGES];
    neg_stage_t       flags_q [STAGES];
    neg_stage_t       flags_d [STAGES];

    assign mode    = neg_mode_e'(mode_i);
    assign inNegEn = (mode == MODE_NEG) || (mode == MODE_NEG2) ||
                     ((mode == MODE_ABS) && data_i[WIDTH-1]);

    // Stage 0 carry-in is the negate enable itself (the "+1" of ~a+1).
    always_comb begin
        inFlags         = '0;
        inFlags.negEn   = inNegEn;
        inFlags.ovfCand = inNegEn && (data_i == MOST_NEG);
        inFlags.carry   = inNegEn;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = ((k + 1) * CHUNK > WIDTH) ? WIDTH : (k + 1) * CHUNK;

        logic [WIDTH-1:0] prevData;
        neg_stage_t       prevFlags;
        logic [WIDTH-1:0] nextData;
        neg_stage_t       nextFlags;

        if (k == 0) begin : g_first
            assign prevData  = data_i;
            assign prevFlags = inFlags;
        end else begin : g_next
            assign prevData  = data_q[k-1];
            assign prevFlags = flags_q[k-1];
        end

        // Ripple through this stage's chunk only; bits outside it pass as-is.
        // Without negation the carry-in is 0 and the chunk is untouched.
        always_comb begin
            logic c;
            logic t;
            nextData  = prevData;
            nextFlags = prevFlags;
            c         = prevFlags.carry;
            t         = 1'b0;
            for (int i = LO; i < HI; i++) begin
                t           = prevData[i] ^ prevFlags.negEn;
                nextData[i] = t ^ c;
                c           = t & c;
            end
            nextFlags.carry = c;
        end

        assign flags_d[k] = nextFlags;

        if (k == STAGES - 1) begin : g_last
`ifdef AU_NEG_PIPE_SAT_EN
            assign data_d[k] = nextFlags.ovfCand ? {1'b0, {(WIDTH-1){1'b1}}} : nextData;
`else
            assign data_d[k] = nextData;
`endif
        end else begin : g_mid
            assign data_d[k] = nextData;
        end
    end

    // All stages move together on advance and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= '0;
                flags_q[k] <= '0;
            end
        end else if (advance_i) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= data_d[k];
                flags_q[k] <= flags_d[k];
            end
        end
    end

    assign data_o = data_q[STAGES-1];
    assign ovf_o  = flags_q[STAGES-1].ovfCand;

endmodule

// File: rtl/au_neg_pipe.sv
// ---------------------------------------------------------------------------
// au_neg_pipe
// Pipelined multi-lane two's-complement negate / absolute-value unit with a
// valid/ready stream handshake. Latency is STAGES cycles; throughput one beat
// per cycle. The whole pipe advances when the output stage is empty or is
// being drained, so in_ready depends combinationally on out_ready.
// Optional feature: AU_NEG_PIPE_SAT_EN saturates overflowing lanes to 011...1.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake
//   in_mode             : 2 bits per lane (pass / neg / abs / neg)
//   in_data             : WIDTH bits per lane, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready : output handshake
//   out_data            : per-lane result
//   out_ovf             : per-lane overflow (negation of the most-negative value)
// ---------------------------------------------------------------------------
module au_neg_pipe
    import au_neg_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*LANES-1:0]     in_mode,
    input  logic [WIDTH*LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    logic [STAGES-1:0] valid_q;
    logic              advance;

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];

    // Shared valid chain; bubbles shift through like real beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        au_neg_pipe_lane #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance_i (advance),
            .mode_i    (in_mode[2*l +: 2]),
            .data_i    (in_data[l*WIDTH +: WIDTH]),
            .data_o    (out_data[l*WIDTH +: WIDTH]),
            .ovf_o     (out_ovf[l])
        );
    end

endmodule

// File: tb/tb_au_neg_pipe.sv
// ---------------------------------------------------------------------------
// tb_au_neg_pipe
// Scoreboard bench for au_neg_pipe. Two instances: A (WIDTH=8, LANES=2,
// STAGES=2) for handshake, stall and reset behaviour, and B (WIDTH=16,
// LANES=1, STAGES=5, uneven chunks) for boundary and random operands.
// Expected results come from a signed-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_au_neg_pipe;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int S  = 2;
    localparam int W2 = 16;
    localparam int S2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic           inValidA, inReadyA, outValidA, outReadyA;
    logic [2*L-1:0] inModeA;
    logic [W*L-1:0] inDataA, outDataA;
    logic [L-1:0]   outOvfA;

    logic           inValidB, inReadyB, outValidB, outReadyB;
    logic [1:0]     inModeB;
    logic [W2-1:0]  inDataB, outDataB;
    logic [0:0]     outOvfB;

    typedef struct { logic [W*L-1:0] data; logic [L-1:0] ovf; } expA_t;
    typedef struct { logic [W2-1:0] data; logic ovf; } expB_t;
    expA_t qA[$];
    expB_t qB[$];

    int tests = 0;
    int fails = 0;

    au_neg_pipe #(.WIDTH(W), .LANES(L), .STAGES(S)) dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidA), .in_ready(inReadyA), .in_mode(inModeA), .in_data(inDataA),
        .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA), .out_ovf(outOvfA)
    );

    au_neg_pipe #(.WIDTH(W2), .LANES(1), .STAGES(S2)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidB), .in_ready(inReadyB), .in_mode(inModeB), .in_data(inDataB),
        .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB), .out_ovf(outOvfB)
    );

    // Reference: interpret operand as signed, negate when the mode asks,
    // reduce modulo 2^w. Returns {ovf, result}.
    function automatic logic [16:0] refLane(input int w, input logic [1:0] mode, input logic [15:0] a);
        longint modv, sv, r;
        bit     neg, ovf;
        modv = longint'(1) << w;
        sv   = (longint'(a) >= modv / 2) ? longint'(a) - modv : longint'(a);
        neg  = (mode == 2'd1) || (mode == 2'd3) || ((mode == 2'd2) && (sv < 0));
        r    = neg ? -sv : sv;
        ovf  = neg && (sv == -(modv / 2));
`ifdef AU_NEG_PIPE_SAT_EN
        if (ovf) r = modv / 2 - 1;
`endif
        r = ((r % modv) + modv) % modv;
        return {ovf, 16'(r)};
    endfunction

    function automatic expA_t modelA(input logic [2*L-1:0] mode, input logic [W*L-1:0] data);
        expA_t       e;
        logic [16:0] t;
        e.data = '0;
        e.ovf  = '0;
        for (int l = 0; l < L; l++) begin
            t = refLane(W, mode[2*l +: 2], {8'h00, data[W*l +: W]});
            e.data[W*l +: W] = t[W-1:0];
            e.ovf[l]         = t[16];
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat into A at a negedge, hold until accepted; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [2*L-1:0] mode, input logic [W*L-1:0] data);
        int  waitCnt;
        bit  accepted;
        waitCnt  = 0;
        accepted = 0;
        @(negedge clk);
        inValidA = 1'b1;
        inModeA  = mode;
        inDataA  = data;
        while (!accepted) begin
            #1;
            if (inReadyA) begin
                accepted = 1;
            end else if (++waitCnt > 100) begin
                checkOutput("acceptTimeoutA", 64'(inReadyA), 64'd1);
                break;
            end else begin
                @(negedge clk);
            end
        end
        if (accepted) qA.push_back(modelA(mode, data));
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusB(input logic [1:0] mode, input logic [W2-1:0] data);
        int          waitCnt;
        bit          accepted;
        logic [16:0] t;
        expB_t       e;
        waitCnt  = 0;
        accepted = 0;
        @(negedge clk);
        inValidB = 1'b1;
        inModeB  = mode;
        inDataB  = data;
        while (!accepted) begin
            #1;
            if (inReadyB) begin
                accepted = 1;
            end else if (++waitCnt > 100) begin
                checkOutput("acceptTimeoutB", 64'(inReadyB), 64'd1);
                break;
            end else begin
                @(negedge clk);
            end
        end
        if (accepted) begin
            t      = refLane(W2, mode, data);
            e.data = t[15:0];
            e.ovf  = t[16];
            qB.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor A: pops the scoreboard on every transfer and checks stall stability.
    initial begin
        expA_t          e;
        logic           stalledPrev;
        logic [W*L-1:0] heldData;
        logic [L-1:0]   heldOvf;
        stalledPrev = 1'b0;
        heldData    = '0;
        heldOvf     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalledPrev = 1'b0;
            end else begin
                if (stalledPrev) begin
                    checkOutput("stallValidA", 64'(outValidA), 64'd1);
                    checkOutput("stallDataA", 64'(outDataA), 64'(heldData));
                    checkOutput("stallOvfA", 64'(outOvfA), 64'(heldOvf));
                end
                stalledPrev = outValidA && !outReadyA;
                if (stalledPrev) begin
                    heldData = outDataA;
                    heldOvf  = outOvfA;
                    checkOutput("inReadyStallA", 64'(inReadyA), 64'd0);
                end
                if (outValidA && outReadyA) begin
                    if (qA.size() == 0) begin
                        checkOutput("unexpectedBeatA", 64'(outValidA), 64'd0);
                    end else begin
                        e = qA.pop_front();
                        checkOutput("dataA", 64'(outDataA), 64'(e.data));
                        checkOutput("ovfA", 64'(outOvfA), 64'(e.ovf));
                    end
                end
            end
        end
    end

    // Monitor B
    initial begin
        expB_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && outValidB && outReadyB) begin
                if (qB.size() == 0) begin
                    checkOutput("unexpectedBeatB", 64'(outValidB), 64'd0);
                end else begin
                    e = qB.pop_front();
                    checkOutput("dataB", 64'(outDataB), 64'(e.data));
                    checkOutput("ovfB", 64'(outOvfB), 64'(e.ovf));
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drainPendingA", 64'(qA.size()), 64'd0);
        checkOutput("drainPendingB", 64'(qB.size()), 64'd0);
    endtask

    initial begin
        logic [15:0] edgeVals [8];
        edgeVals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF, 16'h0F00, 16'h0010};

        rst_n     = 1'b0;
        inValidA  = 1'b0; inModeA = '0; inDataA = '0; outReadyA = 1'b1;
        inValidB  = 1'b0; inModeB = '0; inDataB = '0; outReadyB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValidA", 64'(outValidA), 64'd0);
        checkOutput("rstDataA", 64'(outDataA), 64'd0);
        checkOutput("rstOvfA", 64'(outOvfA), 64'd0);
        checkOutput("rstValidB", 64'(outValidB), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstInReadyA", 64'(inReadyA), 64'd1);

        // Latency: lane0 NEG 05, lane1 NEG 00 (carry crosses the stage boundary)
        applyStimulus(4'b01_01, 16'h00_05);
        checkOutput("latencyEarlyA", 64'(outValidA), 64'd0);
        @(negedge clk);
        inValidA = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("latencyA", 64'(outValidA), 64'd1);

        // Directed corner cases
        applyStimulus(4'b10_01, 16'h80_80);   // lane0 NEG 0x80, lane1 ABS 0x80
        applyStimulus(4'b10_10, 16'h05_FB);   // ABS 0xFB, ABS 0x05
        applyStimulus(4'b11_00, 16'h01_80);   // PASS 0x80, NEG2 0x01
        applyStimulus(4'b00_11, 16'h7F_80);   // NEG2 0x80, PASS 0x7F
        @(negedge clk);
        inValidA = 1'b0;
        drain(20);

        // 20 random beats with out_ready low for five cycles mid-stream
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    applyStimulus(4'($urandom_range(0, 15)), 16'($urandom));
                end
                @(negedge clk);
                inValidA = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                outReadyA = 1'b0;
                repeat (5) @(negedge clk);
                outReadyA = 1'b1;
            end
        join
        drain(40);

        // Reset with two beats in flight
        applyStimulus(4'b01_01, 16'h12_34);
        applyStimulus(4'b10_10, 16'h9A_BC);
        rst_n    = 1'b0;
        inValidA = 1'b0;
        #1;
        checkOutput("midRstValidA", 64'(outValidA), 64'd0);
        checkOutput("midRstDataA", 64'(outDataA), 64'd0);
        checkOutput("midRstOvfA", 64'(outOvfA), 64'd0);
        qA.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postRstInReadyA", 64'(inReadyA), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("postRstNoStaleA", 64'(outValidA), 64'd0);

        // Instance B: boundary operands in every mode, then random
        for (int m = 0; m < 4; m++) begin
            for (int v = 0; v < 8; v++) begin
                applyStimulusB(2'(m), edgeVals[v]);
            end
        end
        for (int i = 0; i < 2000; i++) begin
            applyStimulusB(2'($urandom_range(0, 3)), 16'($urandom));
        end
        @(negedge clk);
        inValidB = 1'b0;
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
